// File: rtl/face_result_pkg.sv
// Shared record layout and frame/window defaults for the detector's
// OS-facing result link.
package face_result_pkg;

    localparam int REC_WIDTH = 32;
    localparam int FIELD_W   = 12;

    localparam logic [1:0] REC_DETECT  = 2'b01;
    localparam logic [1:0] REC_SUMMARY = 2'b10;

    localparam int TYPE_LO  = 30;
    localparam int OVF_BIT  = 24;
    localparam int Y_LO     = 12;
    localparam int X_LO     = 0;
    localparam int IDX_LO   = 12;
    localparam int CNT_LO   = 0;

    localparam int DEF_FIFO_DEPTH      = 16;
    localparam int DEF_FRAME_WIDTH     = 800;
    localparam int DEF_FRAME_HEIGHT    = 600;
    localparam int DEF_INTEGRAL_LENGTH = 24;

    typedef logic [REC_WIDTH-1:0] rec_t;

    function automatic rec_t det_rec(
        input logic [FIELD_W-1:0] x,
        input logic [FIELD_W-1:0] y
    );
        rec_t r;
        r = '0;
        r[TYPE_LO+:2]      = REC_DETECT;
        r[Y_LO+:FIELD_W]   = y;
        r[X_LO+:FIELD_W]   = x;
        return r;
    endfunction

    function automatic rec_t sum_rec(
        input logic               ovf,
        input logic [FIELD_W-1:0] idx,
        input logic [FIELD_W-1:0] cnt
    );
        rec_t r;
        r = '0;
        r[TYPE_LO+:2]      = REC_SUMMARY;
        r[OVF_BIT]         = ovf;
        r[IDX_LO+:FIELD_W] = idx;
        r[CNT_LO+:FIELD_W] = cnt;
        return r;
    endfunction

endpackage

// File: rtl/face_result_if.sv
// Record stream from the result transmitter to the OS consumer.
// master = producer (this block), slave = consumer.
interface face_result_if;
    import face_result_pkg::*;

    logic       o_valid;
    logic       i_ready;
    rec_t       o_data;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);

endinterface

// File: rtl/face_result_fifo.sv
// First-word-fall-through FIFO with registered valid/head outputs
// and an exposed occupancy count.
module face_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk_os,
    input  logic             reset_fpga,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_pop;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop_ok, push_ok;
    logic [WIDTH-1:0] head_d;

    always_comb begin
        pop_ok  = pop_i && (cnt_q != '0);
        push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);
        cnt_pop = cnt_q - CW'(pop_ok);
        cnt_d   = cnt_pop + CW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        wr_d    = wr_q + AW'(push_ok);
        // a push into a queue that is empty after the pop bypasses memory
        head_d  = (push_ok && cnt_pop == '0) ? data_i : mem[rd_d];
        valid_d = (cnt_d != '0);
        data_d  = valid_d ? head_d : data_q;
    end

    always_ff @(posedge clk_os) begin
        if (push_ok) begin
            mem[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_os or posedge reset_fpga) begin
        if (reset_fpga) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/face_result_tx.sv
// Collects window candidates and frame ends, packs them into 32-bit
// records and streams them to the OS through a FWFT FIFO.
module face_result_tx
    import face_result_pkg::*;
#(
    parameter int DATA_WIDTH_12   = 12,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int FRAME_WIDTH     = DEF_FRAME_WIDTH,
    parameter int FRAME_HEIGHT    = DEF_FRAME_HEIGHT,
    parameter int INTEGRAL_LENGTH = DEF_INTEGRAL_LENGTH
) (
    input  logic                     clk_os,
    input  logic                     reset_fpga,
    input  logic                     i_candidate,
    input  logic [DATA_WIDTH_12-1:0] i_xcoord,
    input  logic [DATA_WIDTH_12-1:0] i_ycoord,
    input  logic                     i_frame_end,
    face_result_if.master            os,
    output logic                     o_overflow,
    output logic [DATA_WIDTH_12-1:0] o_frame_count
);

    localparam int DW = DATA_WIDTH_12;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DW-1:0] X_MAX   = DW'(FRAME_WIDTH - INTEGRAL_LENGTH);
    localparam logic [DW-1:0] Y_MAX   = DW'(FRAME_HEIGHT - INTEGRAL_LENGTH);
    localparam logic [CW-1:0] DET_LIM = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] SUM_LIM = CW'(FIFO_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [0:0]    state_q, state_d;
    rec_t          pend_q, pend_d;
    logic [DW-1:0] det_cnt_q, det_cnt_d;
    logic          fovf_q, fovf_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] fcnt_q, fcnt_d;

    logic [CW-1:0] fifo_count;
    logic          push;
    rec_t          push_data;
    logic          pop;

    logic          cand_ok, take, drop;
    logic          room_sum;
    logic [DW-1:0] cnt_inc, cnt_eff;
    logic          flag_eff;
    rec_t          summary;

    always_comb begin
        cand_ok  = i_candidate && (i_xcoord <= X_MAX) && (i_ycoord <= Y_MAX);
        take     = cand_ok && (state_q == S_IDLE) && (fifo_count < DET_LIM);
        drop     = cand_ok && !take;
        room_sum = (fifo_count < SUM_LIM);
        cnt_inc  = (det_cnt_q == '1) ? det_cnt_q : det_cnt_q + 1'b1;
        // a candidate on the frame-end cycle belongs to the ending frame
        cnt_eff  = take ? cnt_inc : det_cnt_q;
        flag_eff = fovf_q || drop;
        summary  = sum_rec(flag_eff, fcnt_q, cnt_eff);
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        det_cnt_d = cnt_eff;
        fovf_d    = flag_eff;
        ovf_d     = ovf_q || drop;
        fcnt_d    = fcnt_q;
        push      = take;
        push_data = det_rec(i_xcoord, i_ycoord);

        unique case (state_q)
            S_IDLE: begin
                if (i_frame_end) begin
                    if (!take && room_sum) begin
                        push      = 1'b1;
                        push_data = summary;
                    end else begin
                        state_d = S_PEND;
                        pend_d  = summary;
                    end
                end
            end
            S_PEND: begin
                if (room_sum) begin
                    push      = 1'b1;
                    push_data = pend_q;
                    state_d   = S_IDLE;
                end
                if (i_frame_end) begin
                    ovf_d = 1'b1;
                end
            end
        endcase

        if (i_frame_end) begin
            fcnt_d    = fcnt_q + 1'b1;
            det_cnt_d = '0;
            fovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_os or posedge reset_fpga) begin
        if (reset_fpga) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            det_cnt_q <= '0;
            fovf_q    <= 1'b0;
            ovf_q     <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            det_cnt_q <= det_cnt_d;
            fovf_q    <= fovf_d;
            ovf_q     <= ovf_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign pop = os.o_valid && os.i_ready;

    face_result_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_os     (clk_os),
        .reset_fpga (reset_fpga),
        .push_i     (push),
        .data_i     (push_data),
        .pop_i      (pop),
        .valid_o    (os.o_valid),
        .data_o     (os.o_data),
        .count_o    (fifo_count)
    );

    assign o_overflow    = ovf_q;
    assign o_frame_count = fcnt_q;

endmodule

// File: tb/tb_face_result_tx.sv
// Bench for face_result_tx: directed scenarios plus random traffic
// checked against a queue-based reference of the record stream.
module tb_face_result_tx;

    logic        clk_os = 1'b0;
    logic        reset_fpga;
    logic        cand;
    logic [11:0] xc, yc;
    logic        fend;
    logic        ovf;
    logic [11:0] fc;

    face_result_if os();

    face_result_tx dut (
        .clk_os        (clk_os),
        .reset_fpga    (reset_fpga),
        .i_candidate   (cand),
        .i_xcoord      (xc),
        .i_ycoord      (yc),
        .i_frame_end   (fend),
        .os            (os),
        .o_overflow    (ovf),
        .o_frame_count (fc)
    );

    always #5 clk_os = ~clk_os;

    int tests = 0;
    int fails = 0;

    logic [31:0] mq[$];
    logic [31:0] got[$];
    int          m_cnt, m_fc;
    bit          m_flag, m_ovf, m_pend;
    logic [31:0] m_pw;

    function automatic logic [31:0] exp_det(input int x, input int y);
        return {2'b01, 6'd0, y[11:0], x[11:0]};
    endfunction

    function automatic logic [31:0] exp_sum(input bit f, input int idx, input int c);
        return {2'b10, 5'd0, f, idx[11:0], c[11:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        got.delete();
        m_cnt = 0; m_fc = 0;
        m_flag = 0; m_ovf = 0; m_pend = 0;
        m_pw = '0;
    endtask

    task automatic check_state();
        chk("valid", 32'(os.o_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("data", os.o_data, mq[0]);
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("frame_count", 32'(fc), 32'(m_fc));
    endtask

    // one clock: drive inputs, advance the reference, compare after the edge
    task automatic step(input bit c, input int x, input int y, input bit fe, input bit rdy);
        bit vc, take;
        int sz;
        logic [31:0] s;
        cand = c; xc = x[11:0]; yc = y[11:0]; fend = fe; os.i_ready = rdy;
        sz = mq.size();
        vc = c && (x <= 800 - 24) && (y <= 600 - 24);
        if (os.o_valid && rdy) got.push_back(os.o_data);
        if (sz > 0 && rdy) void'(mq.pop_front());
        take = 0;
        if (!m_pend) begin
            take = vc && (sz < 15);
            if (take) begin
                mq.push_back(exp_det(x, y));
                if (m_cnt < 4095) m_cnt++;
            end else if (vc) begin
                m_flag = 1; m_ovf = 1;
            end
            if (fe) begin
                s = exp_sum(m_flag, m_fc, m_cnt);
                if (!take && sz < 16) mq.push_back(s);
                else begin m_pend = 1; m_pw = s; end
            end
        end else begin
            if (vc) begin m_flag = 1; m_ovf = 1; end
            if (sz < 16) begin mq.push_back(m_pw); m_pend = 0; end
            if (fe) m_ovf = 1;
        end
        if (fe) begin
            m_fc = (m_fc + 1) % 4096;
            m_cnt = 0; m_flag = 0;
        end
        @(posedge clk_os);
        #1;
        check_state();
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && (mq.size() != 0 || m_pend); i++) idle(1);
        chk("drained", 32'(os.o_valid), 32'd0);
    endtask

    // reset asserted between clock edges, outputs checked before the next edge
    task automatic do_reset();
        cand = 0; fend = 0;
        #3 reset_fpga = 1'b1;
        #1;
        chk("rst_valid", 32'(os.o_valid), 32'd0);
        chk("rst_fcount", 32'(fc), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk_os);
        #1 reset_fpga = 1'b0;
        model_clear();
    endtask

    initial begin
        reset_fpga = 1'b1;
        cand = 0; xc = '0; yc = '0; fend = 0; os.i_ready = 0;
        model_clear();
        #1;
        chk("init_valid", 32'(os.o_valid), 32'd0);
        chk("init_data", os.o_data, 32'd0);
        chk("init_ovf", 32'(ovf), 32'd0);
        chk("init_fcount", 32'(fc), 32'd0);
        @(posedge clk_os);
        #1 reset_fpga = 1'b0;

        // single candidate
        step(1, 100, 50, 0, 1);
        chk("t1_valid", 32'(os.o_valid), 32'd1);
        chk("t1_rec", os.o_data, 32'h4003_2064);
        idle(1);
        chk("t1_empty", 32'(os.o_valid), 32'd0);
        do_reset();

        // three detections then summary
        step(1, 10, 10, 0, 1);
        step(1, 20, 30, 0, 1);
        step(1, 700, 500, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("t2_sum", os.o_data, 32'h8000_0003);
        chk("t2_fcount", 32'(fc), 32'd1);
        idle(1);

        // range boundaries
        step(1, 777, 10, 0, 1);
        step(1, 10, 577, 0, 1);
        chk("t3_ignored", 32'(os.o_valid), 32'd0);
        step(1, 776, 576, 0, 1);
        chk("t3_edge_rec", os.o_data, 32'h4024_0308);
        step(0, 0, 0, 1, 1);
        chk("t3_sum", os.o_data, 32'h8000_1001);
        chk("t3_ovf", 32'(ovf), 32'd0);
        idle(1);

        // backpressure overflow, summary takes the reserved slot
        do_reset();
        for (int i = 0; i < 20; i++) step(1, i * 3, i, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t4_ovf", 32'(ovf), 32'd1);
        drain(40);
        chk("t4_count", got.size(), 32'd16);
        chk("t4_first", got[0], exp_det(0, 0));
        chk("t4_sum", got[15], 32'h8100_000F);

        // simultaneous candidate and frame end
        do_reset();
        for (int i = 0; i < 14; i++) step(1, i, i + 1, 0, 0);
        step(1, 5, 6, 1, 0);
        idle(0);
        drain(40);
        chk("t5_count", got.size(), 32'd16);
        chk("t5_cand", got[14], exp_det(5, 6));
        chk("t5_sum", got[15], 32'h8000_000F);
        chk("t5_ovf", 32'(ovf), 32'd0);

        // summary deferred into a full FIFO, second frame end lost
        do_reset();
        for (int i = 0; i < 15; i++) step(1, i, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 2, 2, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(0);
        idle(0);
        step(0, 0, 0, 1, 0);
        chk("t6_fcount", 32'(fc), 32'd3);
        drain(40);
        chk("t6_count", got.size(), 32'd17);
        chk("t6_sum0", got[15], 32'h8000_000F);
        chk("t6_sum1", got[16], 32'h8100_1000);

        // random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 820)),
                 int'($urandom_range(0, 620)),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) == 0);
        end
        drain(60);

        // asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 40 + i, 7, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(1);
        do_reset();
        step(1, 3, 4, 0, 1);
        step(1, 5, 6, 0, 1);
        step(0, 0, 0, 1, 1);
        drain(10);
        chk("t8_count", got.size(), 32'd3);
        chk("t8_sum", got[2], 32'h8000_0002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
